// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding an LSB-first serializer.
// Bit timing is derived from the shared oversampling tick b_tick; all outputs are registered.
module uart_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int TICK_MAX = (OVERSAMPLE > STOP_TICKS) ? OVERSAMPLE : STOP_TICKS;
  localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] OS_LAST   = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(STOP_TICKS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          ODD_BIT   = (PARITY_ODD != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]           state_reg, state_next;
  logic [TW-1:0]        tick_reg, tick_next;
  logic [BW-1:0]        bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_reg, par_next;
  logic [DATA_BITS-1:0] hold_data_reg, hold_data_next;
  logic                 hold_full_reg, hold_full_next;
  logic                 tx_reg, tx_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;

  always_comb begin
    state_next     = state_reg;
    tick_next      = tick_reg;
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    par_next       = par_reg;
    hold_data_next = hold_data_reg;
    hold_full_next = hold_full_reg;
    done_next      = 1'b0;

    // Writes while full are dropped; the producer must honour tx_ready.
    if (tx_valid && !hold_full_reg) begin
      hold_full_next = 1'b1;
      hold_data_next = tx_data;
    end

    case (state_reg)
      S_IDLE: begin
        if (hold_full_reg) begin
          shift_next     = hold_data_reg;
          hold_full_next = 1'b0;
          tick_next      = '0;
          bit_next       = '0;
          par_next       = 1'b0;
          state_next     = S_START;
        end
      end
      S_START: begin
        if (b_tick) begin
          if (tick_reg == OS_LAST) begin
            tick_next  = '0;
            state_next = S_DATA;
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (b_tick) begin
          if (tick_reg == OS_LAST) begin
            tick_next  = '0;
            shift_next = shift_reg >> 1;
            par_next   = par_reg ^ shift_reg[0];
            if (bit_reg == BIT_LAST) begin
              state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_next = bit_reg + 1'b1;
            end
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (b_tick) begin
          if (tick_reg == OS_LAST) begin
            tick_next  = '0;
            state_next = S_STOP;
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (b_tick) begin
          if (tick_reg == STOP_LAST) begin
            tick_next  = '0;
            done_next  = 1'b1;
            state_next = S_IDLE;
          end else begin
            tick_next = tick_reg + 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Line level follows the state being entered, so tx changes on the transition edge.
    case (state_next)
      S_START:  tx_next = 1'b0;
      S_DATA:   tx_next = shift_next[0];
      S_PARITY: tx_next = par_next ^ ODD_BIT;
      default:  tx_next = 1'b1;
    endcase
    busy_next = (state_next != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      tick_reg      <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      par_reg       <= 1'b0;
      hold_data_reg <= '0;
      hold_full_reg <= 1'b0;
      tx_reg        <= 1'b1;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tick_reg      <= tick_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      par_reg       <= par_next;
      hold_data_reg <= hold_data_next;
      hold_full_reg <= hold_full_next;
      tx_reg        <= tx_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign tx_ready = !hold_full_reg;
  assign tx       = tx_reg;
  assign tx_busy  = busy_reg;
  assign tx_done  = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (plain, even parity, odd parity, 2 stop bits) share clk/b_tick.
// A line monitor records tx per b_tick during each frame and compares it to a frame built from the byte.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       b_tick;
  logic [7:0] tx_data;
  logic [3:0] valid, ready, txl, busy, done;

  always #5 clk = ~clk;

  uart_tx u0 (.clk(clk), .rst(rst), .b_tick(b_tick), .tx_data(tx_data), .tx_valid(valid[0]),
              .tx_ready(ready[0]), .tx(txl[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (.clk(clk), .rst(rst), .b_tick(b_tick), .tx_data(tx_data),
              .tx_valid(valid[1]), .tx_ready(ready[1]), .tx(txl[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (.clk(clk), .rst(rst), .b_tick(b_tick), .tx_data(tx_data),
              .tx_valid(valid[2]), .tx_ready(ready[2]), .tx(txl[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx #(.STOP_TICKS(32)) u3 (.clk(clk), .rst(rst), .b_tick(b_tick), .tx_data(tx_data),
              .tx_valid(valid[3]), .tx_ready(ready[3]), .tx(txl[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         exp_len;
    int         probe_idx;
    logic       probe_val;
  } vec_t;

  vec_t         vecs[6];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [7:0]   sent_q[4][$];
  int           rd_idx[4];
  int           done_cnt[4];
  int           obs_len[4];
  int           last_len[4];
  logic [255:0] obs_bits[4];
  logic [255:0] last_bits[4];
  int           idle_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Expected line level for every b_tick of one frame, straight from the framing rules.
  task automatic build_frame(input int i, input logic [7:0] d, output logic [255:0] v, output int len);
    int   p;
    int   stop;
    logic pb;
    p    = 0;
    v    = '1;
    stop = (i == 3) ? 32 : 16;
    for (int k = 0; k < 16; k++) begin v[p] = 1'b0; p++; end
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < 16; k++) begin v[p] = d[b]; p++; end
    if (i == 1 || i == 2) begin
      pb = (^d) ^ (i == 2);
      for (int k = 0; k < 16; k++) begin v[p] = pb; p++; end
    end
    for (int k = 0; k < stop; k++) begin v[p] = 1'b1; p++; end
    len = p;
  endtask

  task automatic monitor_step();
    logic [255:0] ev;
    int           el;
    logic [7:0]   d;
    bit           bad;
    for (int i = 0; i < 4; i++) begin
      if (rst === 1'b0) begin
        obs_len[i] = 0;
        rd_idx[i]  = sent_q[i].size();
      end else begin
        if (busy[i] === 1'b1 && b_tick === 1'b1) begin
          if (obs_len[i] < 256) obs_bits[i][obs_len[i]] = txl[i];
          obs_len[i]++;
        end
        if (busy[i] !== 1'b1 && txl[i] !== 1'b1) idle_bad++;
        if (done[i] === 1'b1) begin
          done_cnt[i]++;
          last_bits[i] = obs_bits[i];
          last_len[i]  = obs_len[i];
          n_cmp++;
          if (rd_idx[i] >= sent_q[i].size()) begin
            n_bad++;
            $display("FAIL frame_extra[%0d]: got a frame of %0d ticks, required none", i, obs_len[i]);
          end else begin
            d = sent_q[i][rd_idx[i]];
            rd_idx[i]++;
            build_frame(i, d, ev, el);
            bad = (obs_len[i] != el);
            for (int k = 0; k < el && k < 256; k++)
              if (obs_bits[i][k] !== ev[k]) bad = 1'b1;
            if (bad) begin
              n_bad++;
              $display("FAIL frame[%0d] byte %02h: got %0d ticks %h, required %0d ticks %h",
                       i, d, obs_len[i], obs_bits[i], el, ev);
            end
          end
          obs_len[i] = 0;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] d);
    int w;
    w = 0;
    while (ready[i] !== 1'b1 && w < 3000) begin tick(); w++; end
    if (ready[i] !== 1'b1) begin
      check($sformatf("send_ready_timeout[%0d]", i), {31'd0, ready[i]}, 32'd1);
      return;
    end
    tx_data  = d;
    valid[i] = 1'b1;
    sent_q[i].push_back(d);
    tick();
    valid[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int w;
    w = 0;
    while (done[i] !== 1'b1 && w < budget) begin tick(); w++; end
    if (done[i] !== 1'b1) check($sformatf("done_timeout[%0d]", i), {31'd0, done[i]}, 32'd1);
  endtask

  initial begin
    int rb;
    int w;
    int base;
    int ii;
    bit drained;

    vecs[0] = '{inst: 0, data: 8'h55, exp_len: 160, probe_idx: 20,  probe_val: 1'b1};
    vecs[1] = '{inst: 1, data: 8'h07, exp_len: 176, probe_idx: 152, probe_val: 1'b1};
    vecs[2] = '{inst: 2, data: 8'h07, exp_len: 176, probe_idx: 152, probe_val: 1'b0};
    vecs[3] = '{inst: 3, data: 8'h00, exp_len: 176, probe_idx: 175, probe_val: 1'b1};
    vecs[4] = '{inst: 3, data: 8'h00, exp_len: 176, probe_idx: 143, probe_val: 1'b0};
    vecs[5] = '{inst: 0, data: 8'h81, exp_len: 160, probe_idx: 132, probe_val: 1'b1};

    rst      = 1'b0;
    valid    = '0;
    tx_data  = '0;
    b_tick   = 1'b0;
    idle_bad = 0;
    for (int i = 0; i < 4; i++) begin
      rd_idx[i] = 0; done_cnt[i] = 0; obs_len[i] = 0; last_len[i] = 0;
      obs_bits[i] = '0; last_bits[i] = '0;
    end

    fork
      forever begin
        repeat (3) @(posedge clk);
        #1 b_tick = 1'b1;
        @(posedge clk);
        #1 b_tick = 1'b0;
      end
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    repeat (3) tick();
    for (int i = 0; i < 4; i++)
      check($sformatf("reset_outputs[%0d] {tx,ready,busy,done}", i),
            {28'd0, txl[i], ready[i], busy[i], done[i]}, 32'b1100);
    rst = 1'b1;
    tick();

    // Single byte: ready drops for one clk, tx falls as ready returns.
    send(0, 8'h55);
    check("t1_ready_drop", {31'd0, ready[0]}, 32'd0);
    tick();
    check("t1_after_load {ready,busy,tx}", {29'd0, ready[0], busy[0], txl[0]}, 32'b110);
    wait_done(0, 3000);
    tick();
    check("t1_after_done {done,busy,tx}", {29'd0, done[0], busy[0], txl[0]}, 32'b001);
    check("t1_done_count", done_cnt[0], 1);

    // Back-to-back with an overrun attempt while the holding register is full.
    send(0, 8'hA3);
    send(0, 8'h0F);
    check("t2_ready_after_second", {31'd0, ready[0]}, 32'd0);
    tx_data  = 8'hFF;
    valid[0] = 1'b1;
    repeat (3) tick();
    valid[0] = 1'b0;
    rb = 0;
    w  = 0;
    while (done[0] !== 1'b1 && w < 3000) begin
      if (ready[0] !== 1'b0) rb++;
      tick();
      w++;
    end
    check("t2_ready_held_low", rb, 0);
    check("t2_done_and_ready {done,ready}", {30'd0, done[0], ready[0]}, 32'b10);
    tick();
    check("t2_no_idle_bit {busy,tx,ready}", {29'd0, busy[0], txl[0], ready[0]}, 32'b101);
    wait_done(0, 3000);
    repeat (5) tick();

    for (int v = 0; v < 6; v++) begin
      send(vecs[v].inst, vecs[v].data);
      wait_done(vecs[v].inst, 4000);
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_len", v), last_len[vecs[v].inst], vecs[v].exp_len);
      check($sformatf("vec%0d_tick%0d", v, vecs[v].probe_idx),
            {31'd0, last_bits[vecs[v].inst][vecs[v].probe_idx]}, {31'd0, vecs[v].probe_val});
    end
    repeat (50) tick();
    check("t6_line_high_after_stop", {31'd0, txl[3]}, 32'd1);

    // Reset in the middle of data bit 3.
    send(0, 8'hC5);
    w = 0;
    while (obs_len[0] < 72 && w < 3000) begin @(negedge clk); w++; end
    check("t5_reached_bit3", {31'd0, obs_len[0] >= 72}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t5_async_reset {tx,ready,busy}", {29'd0, txl[0], ready[0], busy[0]}, 32'b110);
    base = done_cnt[0];
    repeat (5) tick();
    rst = 1'b1;
    repeat (200) tick();
    check("t5_no_done", done_cnt[0], base);
    check("t5_line_idle", {31'd0, txl[0]}, 32'd1);
    send(0, 8'h81);
    wait_done(0, 3000);

    for (int k = 0; k < 16; k++) begin
      ii = $urandom_range(3, 0);
      repeat ($urandom_range(30, 0)) tick();
      send(ii, 8'($urandom));
    end

    w       = 0;
    drained = 1'b0;
    while (!drained && w < 20000) begin
      tick();
      w++;
      drained = (busy === 4'b0000) && (ready === 4'b1111);
      for (int i = 0; i < 4; i++)
        if (rd_idx[i] != sent_q[i].size()) drained = 1'b0;
    end
    repeat (5) tick();
    for (int i = 0; i < 4; i++)
      check($sformatf("all_frames_sent[%0d]", i), rd_idx[i], sent_q[i].size());
    check("idle_line_high", idle_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
